// File: rtl/opsum_reducer_if.sv
// Handshake and data bundle between a PE-array controller and opsum_reducer.
// The master side drives job control and opsum lanes and consumes the drained row stream.
interface opsum_reducer_if #(
    parameter int ROW_NUM = 32
);
    logic                    start;
    logic [7:0]              pass_num;
    logic                    prod_out_en;
    logic [ROW_NUM*16-1:0]   array_opsum;
    logic                    out_valid;
    logic                    out_ready;
    logic [4:0]              out_row;
    logic signed [15:0]      out_data;
    logic                    busy;
    logic                    done;
    logic                    ovr;

    modport master (
        output start, pass_num, prod_out_en, array_opsum, out_ready,
        input  out_valid, out_row, out_data, busy, done, ovr
    );

    modport slave (
        input  start, pass_num, prod_out_en, array_opsum, out_ready,
        output out_valid, out_row, out_data, busy, done, ovr
    );
endinterface

// File: rtl/opsum_reducer.sv
// Accumulates per-row PE-array opsums over pass_num passes, then streams rows out.
// Define REDUCER_SAT_EN to saturate out_data to 16 bits; otherwise it is truncated.
module opsum_reducer #(
    parameter int ROW_NUM = 32,
    parameter int ACC_W   = 24
) (
    input  logic           clk,
    input  logic           reset,
    opsum_reducer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic [4:0] ROW_LAST = 5'(ROW_NUM - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t     state_q;
    logic [7:0] pass_num_q;
    logic [7:0] pass_cnt_q;
    logic [4:0] row_q;
    logic       valid_q;
    logic       done_q;
    logic       ovr_q;
    logic       pen_q;

    logic                     pen_rise;
    logic                     acc_clr;
    logic                     acc_add;
    logic [ROW_NUM*ACC_W-1:0] acc_flat;
    logic signed [ACC_W-1:0]  sel_acc;
    logic signed [15:0]       narrow_data;

    assign pen_rise = bus.prod_out_en & ~pen_q;
    assign acc_clr  = (state_q == IDLE) && bus.start;
    assign acc_add  = (state_q == ACCUM) && pen_rise;

    genvar gi;
    generate
        for (gi = 0; gi < ROW_NUM; gi++) begin : g_row
            logic [ACC_W-1:0] acc_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_q <= '0;
                end else if (acc_clr) begin
                    acc_q <= '0;
                end else if (acc_add) begin
                    acc_q <= acc_q + ACC_W'($signed(bus.array_opsum[gi*16 +: 16]));
                end
            end
            assign acc_flat[gi*ACC_W +: ACC_W] = acc_q;
        end
    endgenerate

    assign sel_acc = acc_flat[int'(row_q)*ACC_W +: ACC_W];

`ifdef REDUCER_SAT_EN
    always_comb begin
        narrow_data = sel_acc[15:0];
        if (sel_acc > SAT_MAX) begin
            narrow_data = 16'sh7fff;
        end else if (sel_acc < SAT_MIN) begin
            narrow_data = 16'sh8000;
        end
    end
`else
    assign narrow_data = sel_acc[15:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pass_num_q <= '0;
            pass_cnt_q <= '0;
            row_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            pen_q      <= 1'b0;
        end else begin
            pen_q  <= bus.prod_out_en;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        pass_num_q <= (bus.pass_num == 8'd0) ? 8'd1 : bus.pass_num;
                        pass_cnt_q <= '0;
                        // An edge arriving with start is dropped but still flagged.
                        ovr_q      <= pen_rise;
                        state_q    <= ACCUM;
                    end else if (pen_rise) begin
                        ovr_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (pen_rise) begin
                        pass_cnt_q <= pass_cnt_q + 8'd1;
                        if (pass_cnt_q + 8'd1 == pass_num_q) begin
                            state_q <= DRAIN;
                            valid_q <= 1'b1;
                            row_q   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (pen_rise) begin
                        ovr_q <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        if (row_q == ROW_LAST) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            row_q   <= '0;
                        end else begin
                            row_q <= row_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_row   = row_q;
    assign bus.out_data  = (state_q == DRAIN) ? narrow_data : 16'sd0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.ovr       = ovr_q;
endmodule

// File: doc/opsum_reducer.md
OPSUM_REDUCER -- requirements
Module: opsum_reducer

Interface
REQ-001 SHALL have parameter ROW_NUM, default 32, number of PE-array rows/opsum lanes.
REQ-002 SHALL have parameter ACC_W, default 24, signed accumulator width per row.
REQ-003 SHALL have ports clk (input, 1, sole clock) and reset (input, 1); one clock, reset is asynchronous and active-low.
REQ-004 SHALL have start (input, 1), one-cycle pulse that begins a reduction job.
REQ-005 SHALL have pass_num (input, 8), number of PE-array passes to accumulate per job, latched on start.
REQ-006 SHALL have prod_out_en (input, 1), PE-array product-valid window, held high 1..N cycles per pass.
REQ-007 SHALL have array_opsum (input, ROW_NUM*16), signed 16-bit row sums, row r at bits [r*16 +: 16].
REQ-008 SHALL have out_valid (output, 1), out_ready (input, 1), out_row (output, 5), out_data (output, 16, signed): drained row stream.
REQ-009 SHALL have busy (output, 1), done (output, 1, one-cycle pulse) and ovr (output, 1, sticky overrun flag).

Function
REQ-010 SHALL implement FSM IDLE, ACCUM, DRAIN; busy = (state != IDLE).
REQ-011 In IDLE, start SHALL clear all ROW_NUM accumulators, pass_cnt, and ovr, latch pass_num (0 treated as 1), and enter ACCUM next cycle.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 A pass SHALL be sampled only on the rising edge of prod_out_en (high now, low previous cycle); the held cycles after it SHALL NOT be re-accumulated.
REQ-014 On a sampled edge in ACCUM, each acc[r] SHALL += sign-extended array_opsum row r; pass_cnt SHALL increment.
REQ-015 Accumulator addition SHALL wrap modulo 2^ACC_W.
REQ-016 When the sampled edge is pass number latched pass_num, FSM SHALL enter DRAIN the next cycle with out_valid=1, out_row=0.
REQ-017 In DRAIN, out_row/out_data SHALL stay stable while out_valid && !out_ready.
REQ-018 On out_valid && out_ready, out_row SHALL advance by 1. After row ROW_NUM-1 is accepted, the FSM SHALL return to IDLE, pulse done for one cycle, and drop out_valid in the same cycle.
REQ-019 A prod_out_en rising edge in IDLE or DRAIN SHALL set ovr and SHALL NOT modify accumulators; a rising edge in the same cycle as start in IDLE SHALL likewise be ignored and set ovr.
REQ-020 out_data SHALL be derived from acc[out_row] per REQ-026/REQ-027; outside DRAIN, out_data SHALL be 0 and out_valid 0.

Reset
REQ-021 Asserting reset (low) SHALL immediately force state=IDLE and clear all accumulators, pass_cnt, the edge-detect register, out_row, out_valid, out_data, busy, done and ovr to 0.
REQ-022 Reset mid-ACCUM or mid-DRAIN SHALL abandon the job; no done pulse SHALL be issued.
REQ-023 After reset deassertion, the first cycle with prod_out_en already high SHALL count as a rising edge.

Configuration
REQ-024 Macro REDUCER_SAT_EN SHALL select the output narrowing mode.
REQ-025 The macro SHALL affect only out_data; accumulation SHALL be identical in both builds.
REQ-026 With REDUCER_SAT_EN defined, out_data SHALL be acc[out_row] saturated to signed 16-bit range [-32768, 32767].
REQ-027 Without it, out_data SHALL be acc[out_row][15:0] (truncation/wrap).

Verification
REQ-028 pass_num=3; rows all +100 per pass; prod_out_en held 4 cycles per pass -> 32 beats of out_data=300, rows 0..31 in order, one done pulse.
REQ-029 pass_num=0; one pass of row r = r-16 -> treated as 1 pass; out_data(row r) = r-16; done after row 31.
REQ-030 pass_num=2; row 0 = 30000 per pass -> out_data(row 0) = 32767 with REDUCER_SAT_EN, -5536 without.
REQ-031 In DRAIN, out_ready toggled 1,0,0,1 -> out_row holds during stalls, no row skipped or duplicated; a prod_out_en edge injected in DRAIN -> ovr=1, data unchanged.
REQ-032 reset pulsed low after 1 of 4 passes -> all outputs 0 at once; new start, 1-pass job with row value 7 -> out_data=7, prior pass not included.
